// File: rtl/out_reader.sv
// Output buffer between a compute core and a host: fills one result vector,
// holds it until the host asks for it, then streams it out word by word.
module out_reader #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 16,
  parameter int CWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid,
  input  logic [DWIDTH-1:0] core_data,
  input  logic              core_last,
  output logic              core_ready,
  input  logic              host_req,
  input  logic              host_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [CWIDTH-1:0] count,
  output logic              frame_rdy,
  output logic              ovf,
  output logic [1:0]        state_dbg
);

  // Handshakes: a core word transfers on a rising edge where core_valid and
  // core_ready are both 1; an output word transfers where out_valid and
  // host_ready are both 1. out_* hold stable until their transfer.

  localparam int PW = CWIDTH - 1;
  localparam logic [CWIDTH-1:0] CNT_ONE  = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] CNT_TWO  = CWIDTH'(2);
  localparam logic [CWIDTH-1:0] CNT_FULL = CWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {FILL = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              wr_en;

  assign wr_en = core_valid && (state_q == FILL);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      FILL: begin
        if (core_valid) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          // A full buffer closes the frame even without core_last.
          if (core_last || (count_q == CNT_FULL)) state_d = WAIT;
          if (!core_last && (count_q == CNT_FULL)) ovf_d = 1'b1;
        end
      end
      WAIT: begin
        if (host_req) begin
          state_d     = DRAIN;
          out_valid_d = 1'b1;
          out_data_d  = mem[rd_ptr_q];
          out_last_d  = (count_q == CNT_ONE);
          rd_ptr_d    = rd_ptr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (host_ready) begin
          if (out_last_q) begin
            state_d     = FILL;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            // count still includes the word leaving now, so two left means
            // the word being loaded is the final one.
            count_d    = count_q - 1'b1;
            out_data_d = mem[rd_ptr_q];
            out_last_d = (count_q == CNT_TWO);
            rd_ptr_d   = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= core_data;
  end

  assign core_ready = (state_q == FILL);
  assign frame_rdy  = (state_q == WAIT);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign count      = count_q;
  assign ovf        = ovf_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_out_reader.sv
// Bench for out_reader: frames written by a driver are queued as expected
// {last,data} words and checked against the drained stream.
module tb_out_reader;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int CW = 5;
  localparam logic [1:0] S_FILL = 2'd0, S_WAIT = 2'd1, S_DRAIN = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_valid, core_last, core_ready;
  logic [DW-1:0] core_data;
  logic          host_req, host_ready;
  logic          out_valid, out_last, frame_rdy, ovf;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic [1:0]    state_dbg;

  logic [DW:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  out_reader #(.DWIDTH(DW), .DEPTH(DP), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_data(core_data), .core_last(core_last),
    .core_ready(core_ready),
    .host_req(host_req), .host_ready(host_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .count(count), .frame_rdy(frame_rdy), .ovf(ovf), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // driver: writes n words; last marked on word n only if last_en
  task automatic write_frame(input int n, input bit last_en, input bit fixed);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = fixed ? DW'((i + 1) * 16'h0011) : DW'($urandom_range(0, 16'hffff));
      core_valid = 1'b1;
      core_data  = d;
      core_last  = last_en && (i == n - 1);
      exp_q.push_back({(i == n - 1), d});
      step();
    end
    core_valid = 1'b0;
    core_last  = 1'b0;
    chk("frame_rdy_after_fill", {31'd0, frame_rdy}, 32'd1);
    chk("core_ready_after_fill", {31'd0, core_ready}, 32'd0);
    chk("count_after_fill", {27'd0, count}, n);
  endtask

  // mode 0: host_ready=1, mode 1: 1,0,0,1,0,1 pattern, mode 2: random
  task automatic drain(input int mode);
    int nwords, got, cyc;
    bit hr, prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW:0] e;
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    nwords = exp_q.size();
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    chk("out_valid_rise", {31'd0, out_valid}, 32'd1);
    got = 0;
    cyc = 0;
    prev_stall = 0;
    prev_data = '0;
    while (got < nwords && cyc < 300) begin
      hr = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 6] : 1'($urandom_range(0, 1));
      host_ready = hr;
      chk("out_valid_drain", {31'd0, out_valid}, 32'd1);
      if (prev_stall) chk("stall_stable", {16'd0, out_data}, {16'd0, prev_data});
      if (hr) begin
        e = exp_q.pop_front();
        chk("out_word", {15'd0, out_last, out_data}, {15'd0, e});
        got++;
      end
      prev_stall = !hr;
      prev_data  = out_data;
      step();
      cyc++;
    end
    host_ready = 1'b0;
    if (got < nwords) chk("drain_timeout", got, nwords);
    chk("out_valid_end", {31'd0, out_valid}, 32'd0);
    chk("count_end", {27'd0, count}, 32'd0);
    chk("state_end", {30'd0, state_dbg}, {30'd0, S_FILL});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_state", {30'd0, state_dbg}, {30'd0, S_FILL});
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_outs", {28'd0, out_valid, out_last, frame_rdy, ovf}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_core_ready", {31'd0, core_ready}, 32'd1);
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_basic();
    write_frame(4, 1'b1, 1'b1);
    chk("ovf_clear", {31'd0, ovf}, 32'd0);
    drain(0);
  endtask

  task automatic test_overflow();
    write_frame(DP, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    drain(0);
  endtask

  task automatic test_stall();
    write_frame(6, 1'b1, 1'b0);
    drain(1);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
  endtask

  task automatic test_ignore();
    write_frame(2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      core_valid = 1'b1;
      core_data  = DW'($urandom_range(0, 16'hffff));
      core_last  = 1'b1;
      step();
    end
    core_valid = 1'b0;
    core_last  = 1'b0;
    chk("wait_count", {27'd0, count}, 32'd2);
    chk("wait_state", {30'd0, state_dbg}, {30'd0, S_WAIT});
    drain(0);
    host_req = 1'b1;
    step();
    step();
    host_req = 1'b0;
    chk("fill_req_state", {30'd0, state_dbg}, {30'd0, S_FILL});
    chk("fill_req_valid", {31'd0, out_valid}, 32'd0);
    chk("fill_req_count", {27'd0, count}, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [DW:0] e;
    write_frame(3, 1'b1, 1'b0);
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    host_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      chk("mid_word", {15'd0, out_last, out_data}, {15'd0, e});
      step();
    end
    host_ready = 1'b0;
    chk("mid_count", {27'd0, count}, 32'd1);
    apply_reset();
    write_frame(1, 1'b1, 1'b0);
    drain(0);
  endtask

  task automatic test_single();
    write_frame(1, 1'b1, 1'b0);
    drain(2);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      write_frame($urandom_range(1, DP), 1'b1, 1'b0);
      drain(2);
    end
  endtask

  initial begin
    rst = 1'b1;
    core_valid = 1'b0;
    core_data = '0;
    core_last = 1'b0;
    host_req = 1'b0;
    host_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_single();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
